// File: rtl/pc_pkg.sv
// Shared defaults and the next-PC select encoding for the program-counter unit.
package pc_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;
    localparam int unsigned INC_DEF       = 4;
    localparam int unsigned RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_TRAP,
        SEL_RET,
        SEL_CALL,
        SEL_BR,
        SEL_INC
    } next_sel_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; pushing onto a full stack overwrites the oldest
// entry, and pop+push in the same cycle replaces the top in place.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH_DEF,
    parameter int unsigned XLEN  = XLEN_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [XLEN-1:0]        wdata,
    output logic [XLEN-1:0]        top,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   top_idx;
    logic [PW:0]     count_q;
    logic            pop_eff;

    // ptr_q is the next free slot; once full it wraps onto the oldest entry
    assign top_idx = ptr_q - PW'(1);
    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign count   = count_q;
    assign top     = mem[top_idx];
    assign pop_eff = pop && !empty;

    // Pointer and occupancy; pop+push leaves both unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (push && !pop_eff) begin
            ptr_q <= ptr_q + PW'(1);
            if (!full) begin
                count_q <= count_q + (PW+1)'(1);
            end
        end else if (pop_eff && !push) begin
            ptr_q   <= top_idx;
            count_q <= count_q - (PW+1)'(1);
        end
    end

    // Entry storage; a combined pop+push rewrites the current top
    always_ff @(posedge clk) begin
        if (push) begin
            mem[pop_eff ? top_idx : ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: priority next-PC select, alignment check, PC register,
// and an internal return-address stack for call/ret.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEF),
    parameter int unsigned     INC       = INC_DEF,
    parameter int unsigned     RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            trap,
    input  logic            br_taken,
    input  logic            call,
    input  logic            ret,
    input  logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic            misalign,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
    localparam int unsigned     CW         = $clog2(RAS_DEPTH) + 1;

    next_sel_t       sel;
    logic [XLEN-1:0] pc_q, pc_d, pc_inc, target, ras_top;
    logic            valid_q, redirect;
    logic            misalign_q, misalign_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            ras_push, ras_pop, ras_empty, ras_full;
    logic [CW-1:0]   ras_count;

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .XLEN  (XLEN)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ras_push),
        .pop   (ras_pop),
        .wdata (pc_inc),
        .top   (ras_top),
        .count (ras_count),
        .empty (ras_empty),
        .full  (ras_full)
    );

    // Stack flags must agree with the occupancy count
    always_comb begin
        assert (ras_empty == (ras_count == '0));
    end

    assign pc_inc = pc_q + XLEN'(INC);

    // Priority decode; inputs are ignored until pc_valid is up
    always_comb begin
        if (!valid_q)      sel = SEL_HOLD;
        else if (trap)     sel = SEL_TRAP;
        else if (stall)    sel = SEL_HOLD;
        else if (ret)      sel = SEL_RET;
        else if (call)     sel = SEL_CALL;
        else if (br_taken) sel = SEL_BR;
        else               sel = SEL_INC;
    end

    // Next PC, stack control and pulse causes for the selected action
    always_comb begin
        pc_d       = pc_q;
        target     = '0;
        redirect   = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        misalign_d = 1'b0;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        case (sel)
            SEL_TRAP: pc_d = TRAP_VEC;
            SEL_RET: begin
                // ret+call on an empty stack degenerates to a plain push
                ras_pop  = 1'b1;
                ras_push = call;
                redirect = 1'b1;
                if (ras_empty) begin
                    target = br_target;
                    unf_d  = 1'b1;
                end else begin
                    target = ras_top;
                end
            end
            SEL_CALL: begin
                ras_push = 1'b1;
                redirect = 1'b1;
                target   = br_target;
                ovf_d    = ras_full;
            end
            SEL_BR: begin
                redirect = 1'b1;
                target   = br_target;
            end
            SEL_INC: pc_d = pc_inc;
            default: pc_d = pc_q;
        endcase
        if (redirect) begin
            if ((target & ALIGN_MASK) != '0) begin
                pc_d       = TRAP_VEC;
                misalign_d = 1'b1;
            end else begin
                pc_d = target;
            end
        end
    end

    // PC, valid flag and one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VEC;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= 1'b1;
            misalign_q <= misalign_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign pc_out        = pc_q;
    assign pc_valid      = valid_q;
    assign misalign      = misalign_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0, trap = 1'b0, br_taken = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] br_target = '0;
    logic [31:0] pc_out;
    logic        pc_valid, misalign, ras_overflow, ras_underflow;

    int checks = 0;
    int fails  = 0;

    // ctl = {trap, stall, br_taken, call, ret}; ef = {valid, misalign, overflow, underflow}
    typedef struct packed {
        logic [4:0]  ctl;
        logic [31:0] tgt;
        logic [31:0] epc;
        logic [3:0]  ef;
    } vec_t;

    pc_unit #(
        .XLEN      (32),
        .RESET_VEC (32'h0),
        .TRAP_VEC  (32'h100),
        .INC       (4),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .trap          (trap),
        .br_taken      (br_taken),
        .call          (call),
        .ret           (ret),
        .br_target     (br_target),
        .pc_out        (pc_out),
        .pc_valid      (pc_valid),
        .misalign      (misalign),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic [4:0] ctl, input logic [31:0] tgt);
        {trap, stall, br_taken, call, ret} = ctl;
        br_target = tgt;
        @(posedge clk);
        #1;
        {trap, stall, br_taken, call, ret} = 5'b0;
        br_target = '0;
    endtask

    task automatic test_reset();
        vec_t v [4];
        v = '{'{5'b00000, 32'h0, 32'h0, 4'b1000},
              '{5'b00000, 32'h0, 32'h4, 4'b1000},
              '{5'b00000, 32'h0, 32'h8, 4'b1000},
              '{5'b00000, 32'h0, 32'hC, 4'b1000}};
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({pc_out, pc_valid, misalign, ras_overflow, ras_underflow} !== {32'h0, 4'b0000}) begin
            fails++;
            $display("FAIL reset_initial: got pc=%h vmou=%b want pc=00000000 vmou=0000",
                     pc_out, {pc_valid, misalign, ras_overflow, ras_underflow});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(v[i].ctl, v[i].tgt);
            checks++;
            if ({pc_out, pc_valid, misalign, ras_overflow, ras_underflow} !== {v[i].epc, v[i].ef}) begin
                fails++;
                $display("FAIL reset_run[%0d]: got pc=%h vmou=%b want pc=%h vmou=%b", i,
                         pc_out, {pc_valid, misalign, ras_overflow, ras_underflow}, v[i].epc, v[i].ef);
            end
        end
        // mid-cycle reset must act without a clock edge
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pc_out, pc_valid} !== {32'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset_async: got pc=%h valid=%b want pc=00000000 valid=0", pc_out, pc_valid);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if ({pc_out, pc_valid} !== {32'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset_release: got pc=%h valid=%b want pc=00000000 valid=0", pc_out, pc_valid);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(v[i].ctl, v[i].tgt);
            checks++;
            if ({pc_out, pc_valid, misalign, ras_overflow, ras_underflow} !== {v[i].epc, v[i].ef}) begin
                fails++;
                $display("FAIL reset_rerun[%0d]: got pc=%h vmou=%b want pc=%h vmou=%b", i,
                         pc_out, {pc_valid, misalign, ras_overflow, ras_underflow}, v[i].epc, v[i].ef);
            end
        end
    endtask

    task automatic test_stall_trap();
        vec_t v [4];
        v = '{'{5'b01000, 32'h0,  32'h8,   4'b1000},
              '{5'b01000, 32'h40, 32'h8,   4'b1000},
              '{5'b11000, 32'h0,  32'h100, 4'b1000},
              '{5'b00000, 32'h0,  32'h104, 4'b1000}};
        for (int i = 0; i < 4; i++) begin
            cycle(v[i].ctl, v[i].tgt);
            checks++;
            if ({pc_out, pc_valid, misalign, ras_overflow, ras_underflow} !== {v[i].epc, v[i].ef}) begin
                fails++;
                $display("FAIL stall_trap[%0d]: got pc=%h vmou=%b want pc=%h vmou=%b", i,
                         pc_out, {pc_valid, misalign, ras_overflow, ras_underflow}, v[i].epc, v[i].ef);
            end
        end
    endtask

    task automatic test_branch();
        vec_t v [3];
        v = '{'{5'b00100, 32'h40, 32'h40,  4'b1000},
              '{5'b00100, 32'h42, 32'h100, 4'b1100},
              '{5'b00000, 32'h0,  32'h104, 4'b1000}};
        for (int i = 0; i < 3; i++) begin
            cycle(v[i].ctl, v[i].tgt);
            checks++;
            if ({pc_out, pc_valid, misalign, ras_overflow, ras_underflow} !== {v[i].epc, v[i].ef}) begin
                fails++;
                $display("FAIL branch[%0d]: got pc=%h vmou=%b want pc=%h vmou=%b", i,
                         pc_out, {pc_valid, misalign, ras_overflow, ras_underflow}, v[i].epc, v[i].ef);
            end
        end
    endtask

    task automatic test_calls();
        vec_t v [11];
        v = '{'{5'b00100, 32'h10, 32'h10, 4'b1000},
              '{5'b00010, 32'h20, 32'h20, 4'b1000},
              '{5'b00010, 32'h30, 32'h30, 4'b1000},
              '{5'b00010, 32'h40, 32'h40, 4'b1000},
              '{5'b00010, 32'h50, 32'h50, 4'b1000},
              '{5'b00010, 32'h60, 32'h60, 4'b1010},
              '{5'b00001, 32'h70, 32'h54, 4'b1000},
              '{5'b00001, 32'h70, 32'h44, 4'b1000},
              '{5'b00001, 32'h70, 32'h34, 4'b1000},
              '{5'b00001, 32'h70, 32'h24, 4'b1000},
              '{5'b00001, 32'h70, 32'h70, 4'b1001}};
        for (int i = 0; i < 11; i++) begin
            cycle(v[i].ctl, v[i].tgt);
            checks++;
            if ({pc_out, pc_valid, misalign, ras_overflow, ras_underflow} !== {v[i].epc, v[i].ef}) begin
                fails++;
                $display("FAIL calls[%0d]: got pc=%h vmou=%b want pc=%h vmou=%b", i,
                         pc_out, {pc_valid, misalign, ras_overflow, ras_underflow}, v[i].epc, v[i].ef);
            end
        end
    endtask

    task automatic test_pop_push();
        vec_t v [9];
        v = '{'{5'b00100, 32'h20,  32'h20,  4'b1000},
              '{5'b00010, 32'h80,  32'h80,  4'b1000},
              '{5'b00011, 32'h200, 32'h24,  4'b1000},
              '{5'b00001, 32'h200, 32'h84,  4'b1000},
              '{5'b00001, 32'h300, 32'h300, 4'b1001},
              '{5'b00011, 32'h400, 32'h400, 4'b1001},
              '{5'b00001, 32'h500, 32'h304, 4'b1000},
              '{5'b00010, 32'h42,  32'h100, 4'b1100},
              '{5'b00001, 32'h0,   32'h308, 4'b1000}};
        for (int i = 0; i < 9; i++) begin
            cycle(v[i].ctl, v[i].tgt);
            checks++;
            if ({pc_out, pc_valid, misalign, ras_overflow, ras_underflow} !== {v[i].epc, v[i].ef}) begin
                fails++;
                $display("FAIL pop_push[%0d]: got pc=%h vmou=%b want pc=%h vmou=%b", i,
                         pc_out, {pc_valid, misalign, ras_overflow, ras_underflow}, v[i].epc, v[i].ef);
            end
        end
    endtask

    task automatic test_wrap();
        vec_t v [3];
        v = '{'{5'b00100, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 4'b1000},
              '{5'b00000, 32'h0,         32'h0,         4'b1000},
              '{5'b00000, 32'h0,         32'h4,         4'b1000}};
        for (int i = 0; i < 3; i++) begin
            cycle(v[i].ctl, v[i].tgt);
            checks++;
            if ({pc_out, pc_valid, misalign, ras_overflow, ras_underflow} !== {v[i].epc, v[i].ef}) begin
                fails++;
                $display("FAIL wrap[%0d]: got pc=%h vmou=%b want pc=%h vmou=%b", i,
                         pc_out, {pc_valid, misalign, ras_overflow, ras_underflow}, v[i].epc, v[i].ef);
            end
        end
    endtask

    task automatic test_reset_ras();
        vec_t v [3];
        v = '{'{5'b00010, 32'h10,  32'h10,  4'b1000},
              '{5'b00000, 32'h0,   32'h0,   4'b1000},
              '{5'b00001, 32'h600, 32'h600, 4'b1001}};
        cycle(v[0].ctl, v[0].tgt);
        checks++;
        if ({pc_out, pc_valid, misalign, ras_overflow, ras_underflow} !== {v[0].epc, v[0].ef}) begin
            fails++;
            $display("FAIL reset_ras_call: got pc=%h vmou=%b want pc=%h vmou=%b",
                     pc_out, {pc_valid, misalign, ras_overflow, ras_underflow}, v[0].epc, v[0].ef);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pc_out, pc_valid} !== {32'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset_ras_async: got pc=%h valid=%b want pc=00000000 valid=0", pc_out, pc_valid);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 1; i < 3; i++) begin
            cycle(v[i].ctl, v[i].tgt);
            checks++;
            if ({pc_out, pc_valid, misalign, ras_overflow, ras_underflow} !== {v[i].epc, v[i].ef}) begin
                fails++;
                $display("FAIL reset_ras[%0d]: got pc=%h vmou=%b want pc=%h vmou=%b", i,
                         pc_out, {pc_valid, misalign, ras_overflow, ras_underflow}, v[i].epc, v[i].ef);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall_trap();
        test_branch();
        test_calls();
        test_pop_push();
        test_wrap();
        test_reset_ras();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit; successor to the plain registered PC. Selects and registers the next fetch address from sequential increment, branch/jump target, call/return via an internal return-address stack (RAS), or trap vector. Supports stall, alignment checking and reset-vector configuration. Sits between decode/execute redirect logic and the instruction-memory address port.

## Interface
- XLEN, 32: address width.
- RESET_VEC, 0: pc_out value at and after reset.
- TRAP_VEC, 32'h100: target on trap or misaligned redirect.
- INC, 4: sequential increment, power of two.
- RAS_DEPTH, 4: return-address stack entries, ≥2, power of two.

- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hold pc_out and RAS.
- trap  in  1  redirect to TRAP_VEC.
- br_taken  in  1  redirect to br_target.
- call  in  1  jump to br_target, push pc_out+INC.
- ret  in  1  jump to RAS top, pop.
- br_target  in  XLEN  redirect target.
- pc_out  out  XLEN  current fetch address.
- pc_valid  out  1  pc_out is a valid fetch address.
- misalign  out  1  one-cycle pulse: redirect target not INC-aligned.
- ras_overflow  out  1  one-cycle pulse: push onto full RAS.
- ras_underflow  out  1  one-cycle pulse: ret on empty RAS.

## Operation
- Reset (rst_n=0): pc_out=RESET_VEC, pc_valid=0, RAS count=0, all pulses 0. Takes effect immediately, regardless of clk.
- First rising edge after release: pc_valid←1, pc_out stays RESET_VEC. Later edges evaluate the priority below.
- Priority per edge: trap > stall > ret > call > br_taken > increment.
- trap: pc_out←TRAP_VEC. Overrides stall. RAS untouched.
- stall (no trap): pc_out, RAS and count hold. Pulses are 0.
- ret, count>0: pc_out←RAS top, pop.
- ret, count=0: pc_out←br_target, ras_underflow=1, no pop.
- ret+call together: pop-then-push. pc_out←old top; top←pc_out+INC; count unchanged. If count=0, this is a push only, pc_out←br_target, ras_underflow=1.
- call: push pc_out+INC, pc_out←br_target.
- call with count=RAS_DEPTH: oldest entry is overwritten (circular), count stays RAS_DEPTH, ras_overflow=1.
- br_taken: pc_out←br_target.
- Otherwise: pc_out←pc_out+INC, modulo 2^XLEN (wraps to 0, no flag).
- Misaligned: any redirect to br_target or RAS top with nonzero low log2(INC) bits sends pc_out←TRAP_VEC and pulses misalign=1. RAS push/pop still happen as selected.
- Pulses are registered and valid in the cycle after the causing edge, alongside the new pc_out.

## Timing
- Single-cycle latency: inputs sampled at edge N appear on pc_out after edge N.
- No combinational path from inputs to outputs.
- Reset assertion mid-operation clears RAS and count, and drops pc_valid asynchronously.
- Inputs are ignored while pc_valid=0, including the release cycle.

## Structure
- Package pc_pkg holds the default XLEN/RESET_VEC/TRAP_VEC/INC and a next-PC select enum: SEL_HOLD, SEL_TRAP, SEL_RET, SEL_CALL, SEL_BR, SEL_INC.
- Sub-module pc_ras is the circular stack. It has parameters DEPTH and XLEN; inputs push, pop, wdata; outputs top, count, empty, full. It implements pop+push as replace-top.
- pc_unit holds the priority decoder, alignment check and pc register.

## Test plan
- Reset: rst_n low mid-run → pc_out=0, pc_valid=0 immediately. Release, then 3 idle edges → pc_out 0, 0, 4, 8 with pc_valid=1 from first edge.
- Stall/trap: stall for 2 edges at pc=8 → pc_out holds 8. stall+trap → pc_out=0x100.
- Branch: br_taken with br_target=0x40 → 0x40. br_target=0x42 → pc_out=0x100, misalign pulse for one cycle.
- Calls with RAS_DEPTH=4: calls at pc 0x10, 0x20, 0x30, 0x40, 0x50 → ras_overflow on the 5th call. Then 5 rets → return to 0x54, 0x44, 0x34, 0x24, with ras_underflow on the 5th ret and pc_out=br_target.
- Pop-then-push: call+ret together with top=0x24 at pc 0x80 → pc_out=0x24, top becomes 0x84, count unchanged.
- Wrap: pc_out=0xFFFFFFFC, idle edge → pc_out=0x00000000, no flags.
